// File: rtl/i2c_ctrl_buffer.sv
// Host-side byte buffering for an I2C core: TX/RX FIFOs with handshake feeders,
// plus filtered bus monitoring for busy and stuck-SCL detection.
module i2c_ctrl_buffer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned RX_DEPTH  = 4,
    parameter int unsigned FILT_LEN  = 3,
    parameter int unsigned STUCK_CYC = 1023
) (
    input  logic                       clk,
    input  logic                       rst_sync_n,
    input  logic                       flush,
    input  logic                       tx_wr_en,
    input  logic [DATA_W-1:0]          tx_data,
    output logic                       tx_full,
    output logic [$clog2(TX_DEPTH):0]  tx_level,
    input  logic                       rx_rd_en,
    output logic [DATA_W-1:0]          rx_data,
    output logic                       rx_empty,
    output logic [$clog2(RX_DEPTH):0]  rx_level,
    output logic                       err_ovf,
    output logic                       err_udf,
    input  logic                       core_wr_reg_empty,
    output logic                       core_wr_rdy,
    output logic [DATA_W-1:0]          core_byte_wr,
    input  logic                       core_rd_reg_full,
    input  logic [DATA_W-1:0]          core_byte_rd,
    output logic                       core_rd_clr,
    input  logic                       scl_i,
    input  logic                       sda_i,
    output logic                       bus_busy,
    output logic                       bus_stuck
);
    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned FC_W  = $clog2(FILT_LEN + 1);
    localparam int unsigned SC_W  = $clog2(STUCK_CYC + 1);

    typedef enum logic [1:0] {T_IDLE, T_PUSH, T_WAIT} t_state_e;
    typedef enum logic [1:0] {R_IDLE, R_CLR, R_WAIT} r_state_e;

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [TX_AW:0]    tx_wp_q, tx_rp_q;
    logic [RX_AW:0]    rx_wp_q, rx_rp_q;
    t_state_e          t_state_q;
    r_state_e          r_state_q;
    logic              wr_rdy_q, rd_clr_q, ovf_q, udf_q;
    logic [DATA_W-1:0] byte_wr_q;

    logic tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
    logic tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;

    assign tx_full_c  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) && (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
    assign tx_empty_c = (tx_wp_q == tx_rp_q);
    assign rx_full_c  = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) && (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
    assign rx_empty_c = (rx_wp_q == rx_rp_q);

    assign tx_push_c = tx_wr_en && !tx_full_c && !flush;
    assign tx_pop_c  = (t_state_q == T_IDLE) && !tx_empty_c && core_wr_reg_empty && !flush;
    assign rx_push_c = (r_state_q == R_CLR) && !rx_full_c && !flush;
    assign rx_pop_c  = rx_rd_en && !rx_empty_c && !flush;

    // FIFO storage and pointers; flush wins over any push or pop
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
        end else if (flush) begin
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
        end else begin
            if (tx_push_c) begin
                tx_mem_q[tx_wp_q[TX_AW-1:0]] <= tx_data;
                tx_wp_q <= tx_wp_q + (TX_AW+1)'(1);
            end
            if (tx_pop_c)  tx_rp_q <= tx_rp_q + (TX_AW+1)'(1);
            if (rx_push_c) begin
                rx_mem_q[rx_wp_q[RX_AW-1:0]] <= core_byte_rd;
                rx_wp_q <= rx_wp_q + (RX_AW+1)'(1);
            end
            if (rx_pop_c)  rx_rp_q <= rx_rp_q + (RX_AW+1)'(1);
        end
    end

    // Sticky error flags
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if ((tx_wr_en && tx_full_c) || ((r_state_q == R_CLR) && rx_full_c)) ovf_q <= 1'b1;
            if (rx_rd_en && rx_empty_c) udf_q <= 1'b1;
        end
    end

    // TX feeder: byte is popped on entry to T_PUSH, strobe is issued on leaving it
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            t_state_q <= T_IDLE;
            wr_rdy_q  <= 1'b0;
            byte_wr_q <= '0;
        end else if (flush) begin
            t_state_q <= T_IDLE;
            wr_rdy_q  <= 1'b0;
            byte_wr_q <= '0;
        end else begin
            wr_rdy_q <= 1'b0;
            case (t_state_q)
                T_IDLE: if (tx_pop_c) begin
                    byte_wr_q <= tx_mem_q[tx_rp_q[TX_AW-1:0]];
                    t_state_q <= T_PUSH;
                end
                T_PUSH: begin
                    wr_rdy_q  <= 1'b1;
                    t_state_q <= T_WAIT;
                end
                T_WAIT:  if (!core_wr_reg_empty) t_state_q <= T_IDLE;
                default: t_state_q <= T_IDLE;
            endcase
        end
    end

    // RX drain: stalls in R_IDLE while the FIFO is full so the core stretches SCL
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            r_state_q <= R_IDLE;
            rd_clr_q  <= 1'b0;
        end else if (flush) begin
            r_state_q <= R_IDLE;
            rd_clr_q  <= 1'b0;
        end else begin
            rd_clr_q <= 1'b0;
            case (r_state_q)
                R_IDLE:  if (core_rd_reg_full && !rx_full_c) r_state_q <= R_CLR;
                R_CLR: begin
                    rd_clr_q  <= 1'b1;
                    r_state_q <= R_WAIT;
                end
                R_WAIT:  if (!core_rd_reg_full) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Bus line conditioning: bit 0 is SCL, bit 1 is SDA
    logic [1:0] raw_c, filt_c, filt_prev_q;
    assign raw_c = {sda_i, scl_i};

    for (genvar g = 0; g < 2; g++) begin : g_line
        logic [1:0]      sync_q;
        logic            filt_q;
        logic [FC_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_sync_n) begin
            if (!rst_sync_n) begin
                sync_q <= 2'b11;
                filt_q <= 1'b1;
                cnt_q  <= '0;
            end else begin
                sync_q <= {sync_q[0], raw_c[g]};
                if (sync_q[1] == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == FC_W'(FILT_LEN - 1)) begin
                    filt_q <= sync_q[1];
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + FC_W'(1);
                end
            end
        end
        assign filt_c[g] = filt_q;
    end

    logic            start_c, stop_c, scl_chg_c, busy_q, stuck_q;
    logic [SC_W-1:0] scnt_q;

    assign start_c   = filt_c[0] &&  filt_prev_q[1] && !filt_c[1];
    assign stop_c    = filt_c[0] && !filt_prev_q[1] &&  filt_c[1];
    assign scl_chg_c = filt_c[0] != filt_prev_q[0];

    // Busy tracking and stuck-SCL watchdog; START takes priority over STOP
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            filt_prev_q <= 2'b11;
            busy_q      <= 1'b0;
            stuck_q     <= 1'b0;
            scnt_q      <= '0;
        end else begin
            filt_prev_q <= filt_c;
            if (start_c) begin
                busy_q  <= 1'b1;
                stuck_q <= 1'b0;
                scnt_q  <= '0;
            end else if (stop_c || !busy_q || scl_chg_c) begin
                busy_q <= busy_q && !stop_c;
                scnt_q <= '0;
            end else if (scnt_q == SC_W'(STUCK_CYC - 1)) begin
                busy_q  <= 1'b0;
                stuck_q <= 1'b1;
                scnt_q  <= '0;
            end else begin
                scnt_q <= scnt_q + SC_W'(1);
            end
        end
    end

    assign tx_full      = tx_full_c;
    assign tx_level     = tx_wp_q - tx_rp_q;
    assign rx_empty     = rx_empty_c;
    assign rx_level     = rx_wp_q - rx_rp_q;
    assign rx_data      = rx_mem_q[rx_rp_q[RX_AW-1:0]];
    assign err_ovf      = ovf_q;
    assign err_udf      = udf_q;
    assign core_wr_rdy  = wr_rdy_q;
    assign core_byte_wr = byte_wr_q;
    assign core_rd_clr  = rd_clr_q;
    assign bus_busy     = busy_q;
    assign bus_stuck    = stuck_q;
endmodule

// File: tb/tb_i2c_ctrl_buffer.sv
// Bench for i2c_ctrl_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_i2c_ctrl_buffer;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned TX_DEPTH  = 4;
    localparam int unsigned RX_DEPTH  = 4;
    localparam int unsigned FILT_LEN  = 3;
    localparam int unsigned STUCK_CYC = 40;

    logic              clk = 1'b0;
    logic              rst_sync_n = 1'b0;
    logic              flush = 1'b0;
    logic              tx_wr_en = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_full;
    logic [2:0]        tx_level;
    logic              rx_rd_en = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic [2:0]        rx_level;
    logic              err_ovf, err_udf;
    logic              core_wr_reg_empty = 1'b0;
    logic              core_wr_rdy;
    logic [DATA_W-1:0] core_byte_wr;
    logic              core_rd_reg_full = 1'b0;
    logic [DATA_W-1:0] core_byte_rd = '0;
    logic              core_rd_clr;
    logic              scl_i = 1'b1, sda_i = 1'b1;
    logic              bus_busy, bus_stuck;

    i2c_ctrl_buffer #(
        .DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
        .FILT_LEN(FILT_LEN), .STUCK_CYC(STUCK_CYC)
    ) dut (
        .clk(clk), .rst_sync_n(rst_sync_n), .flush(flush),
        .tx_wr_en(tx_wr_en), .tx_data(tx_data), .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd_en(rx_rd_en), .rx_data(rx_data), .rx_empty(rx_empty), .rx_level(rx_level),
        .err_ovf(err_ovf), .err_udf(err_udf),
        .core_wr_reg_empty(core_wr_reg_empty), .core_wr_rdy(core_wr_rdy), .core_byte_wr(core_byte_wr),
        .core_rd_reg_full(core_rd_reg_full), .core_byte_rd(core_byte_rd), .core_rd_clr(core_rd_clr),
        .scl_i(scl_i), .sda_i(sda_i), .bus_busy(bus_busy), .bus_stuck(bus_stuck)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [DATA_W-1:0]   txq[$];
    logic [DATA_W-1:0]   rxq[$];
    bit                  m_ovf, m_udf, m_rdy, m_clr, m_busy, m_stuck;
    logic [DATA_W-1:0]   m_wbyte;
    bit                  tx_taken, tx_open, rx_taken, rx_open;
    logic [FILT_LEN+1:0] hscl, hsda;
    bit                  mf_scl, mf_sda, mp_scl, mp_sda;
    int                  quiet;

    task automatic model_reset();
        txq.delete(); rxq.delete();
        m_ovf = 0; m_udf = 0; m_rdy = 0; m_clr = 0; m_busy = 0; m_stuck = 0;
        m_wbyte = '0;
        tx_taken = 0; tx_open = 0; rx_taken = 0; rx_open = 0;
        hscl = '1; hsda = '1;
        mf_scl = 1; mf_sda = 1; mp_scl = 1; mp_sda = 1;
        quiet = 0;
    endtask

    task automatic model_step();
        bit st, sp, chg, old_tt, old_rt;
        int tsz, rsz;
        logic [FILT_LEN-1:0] win;
        // bus: conditions come from the filtered levels of the last two cycles
        st  = mf_scl && mp_sda && !mf_sda;
        sp  = mf_scl && !mp_sda && mf_sda;
        chg = mf_scl != mp_scl;
        if (st) begin
            m_busy = 1; m_stuck = 0; quiet = 0;
        end else if (sp) begin
            m_busy = 0; quiet = 0;
        end else if (m_busy && !chg) begin
            quiet++;
            if (quiet == STUCK_CYC) begin
                m_stuck = 1; m_busy = 0; quiet = 0;
            end
        end else begin
            quiet = 0;
        end
        mp_scl = mf_scl; mp_sda = mf_sda;
        hscl = {hscl[FILT_LEN:0], scl_i};
        hsda = {hsda[FILT_LEN:0], sda_i};
        win = hscl[FILT_LEN+1:2];
        if (&win) mf_scl = 1; else if (~|win) mf_scl = 0;
        win = hsda[FILT_LEN+1:2];
        if (&win) mf_sda = 1; else if (~|win) mf_sda = 0;

        tsz = txq.size(); rsz = rxq.size();
        old_tt = tx_taken; old_rt = rx_taken;
        if (flush) begin
            txq.delete(); rxq.delete();
            tx_taken = 0; tx_open = 0; rx_taken = 0; rx_open = 0;
            m_rdy = 0; m_clr = 0; m_wbyte = '0; m_ovf = 0; m_udf = 0;
        end else begin
            // TX: one strobe per byte, core must drop its empty flag before the next
            if (tx_wr_en && tsz == TX_DEPTH) m_ovf = 1;
            m_rdy = old_tt; tx_taken = 0;
            if (!tx_open && tsz > 0 && core_wr_reg_empty) begin
                m_wbyte = txq.pop_front(); tx_taken = 1; tx_open = 1;
            end else if (tx_open && !old_tt && !core_wr_reg_empty) begin
                tx_open = 0;
            end
            if (tx_wr_en && tsz < TX_DEPTH) txq.push_back(tx_data);
            // RX: take a core byte only when room exists
            if (rx_rd_en) begin
                if (rsz == 0) m_udf = 1;
                else void'(rxq.pop_front());
            end
            m_clr = old_rt; rx_taken = 0;
            if (old_rt) rxq.push_back(core_byte_rd);
            if (!rx_open && core_rd_reg_full && rsz < RX_DEPTH) begin
                rx_taken = 1; rx_open = 1;
            end else if (rx_open && !old_rt && !core_rd_reg_full) begin
                rx_open = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("tx_level", 32'(tx_level), 32'(txq.size()));
        chk("tx_full", 32'(tx_full), 32'(txq.size() == TX_DEPTH));
        chk("rx_level", 32'(rx_level), 32'(rxq.size()));
        chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
        if (rxq.size() > 0) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("err_udf", 32'(err_udf), 32'(m_udf));
        chk("core_wr_rdy", 32'(core_wr_rdy), 32'(m_rdy));
        if (m_rdy) chk("core_byte_wr", 32'(core_byte_wr), 32'(m_wbyte));
        chk("core_rd_clr", 32'(core_rd_clr), 32'(m_clr));
        chk("bus_busy", 32'(bus_busy), 32'(m_busy));
        chk("bus_stuck", 32'(bus_stuck), 32'(m_stuck));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_wr(input int lim, output bit seen, output logic [DATA_W-1:0] b);
        seen = 0; b = '0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (core_wr_rdy) begin
                seen = 1; b = core_byte_wr;
            end
        end
    endtask

    task automatic wait_clr(input int lim, output bit seen);
        seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (core_rd_clr) seen = 1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_level"}, 32'(tx_level), 0);
        chk({tag, "_tx_full"}, 32'(tx_full), 0);
        chk({tag, "_rx_level"}, 32'(rx_level), 0);
        chk({tag, "_rx_empty"}, 32'(rx_empty), 1);
        chk({tag, "_rx_data"}, 32'(rx_data), 0);
        chk({tag, "_err_ovf"}, 32'(err_ovf), 0);
        chk({tag, "_err_udf"}, 32'(err_udf), 0);
        chk({tag, "_core_byte_wr"}, 32'(core_byte_wr), 0);
        chk({tag, "_core_wr_rdy"}, 32'(core_wr_rdy), 0);
        chk({tag, "_core_rd_clr"}, 32'(core_rd_clr), 0);
        chk({tag, "_bus_busy"}, 32'(bus_busy), 0);
        chk({tag, "_bus_stuck"}, 32'(bus_stuck), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [DATA_W-1:0] b;
        int cnt;
        model_reset();
        #12;
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst_sync_n = 1'b1;
        tick(2);

        // Fill TX past capacity with the core not ready
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'(8'h11 + i); tx_wr_en = 1'b1;
            tick(1);
            if (i == 3) begin
                @(negedge clk);
                chk("tx_full_after_4", 32'(tx_full), 1);
            end
        end
        tx_wr_en = 1'b0;
        @(negedge clk);
        chk("err_ovf_after_5", 32'(err_ovf), 1);
        chk("tx_level_full", 32'(tx_level), 4);
        core_wr_reg_empty = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_wr(10, seen, b);
            chk("tx_strobe_seen", 32'(seen), 1);
            chk("tx_byte_order", 32'(b), 32'(8'h11 + k));
            tick(1); core_wr_reg_empty = 1'b0;
            tick(1); core_wr_reg_empty = 1'b1;
        end
        wait_wr(8, seen, b);
        chk("tx_no_fifth_byte", 32'(seen), 0);
        chk("tx_drained", 32'(tx_level), 0);
        tick(1); flush = 1'b1; tick(1); flush = 1'b0;
        @(negedge clk);
        chk("flush_clears_ovf", 32'(err_ovf), 0);

        // Core keeps its register empty: no repeat strobe until it toggles
        tick(1);
        tx_data = 8'h21; tx_wr_en = 1'b1; tick(1);
        tx_data = 8'h22; tick(1);
        tx_wr_en = 1'b0;
        wait_wr(10, seen, b);
        chk("hold_first_byte", 32'(b), 32'h21);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (core_wr_rdy) cnt++;
        end
        chk("hold_no_second_strobe", 32'(cnt), 0);
        tick(1); core_wr_reg_empty = 1'b0;
        tick(1); core_wr_reg_empty = 1'b1;
        wait_wr(10, seen, b);
        chk("hold_second_byte", 32'(b), 32'h22);
        tick(1); core_wr_reg_empty = 1'b0;
        tick(1);

        // Fill RX from the core, then stall on a full FIFO
        for (int k = 0; k < 4; k++) begin
            core_byte_rd = 8'(8'h40 + k); core_rd_reg_full = 1'b1;
            wait_clr(10, seen);
            chk("rx_clr_seen", 32'(seen), 1);
            tick(1); core_rd_reg_full = 1'b0;
            tick(1);
        end
        @(negedge clk);
        chk("rx_level_full", 32'(rx_level), 4);
        chk("rx_head_first", 32'(rx_data), 32'h40);
        tick(1);
        core_byte_rd = 8'hA5; core_rd_reg_full = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (core_rd_clr) cnt++;
        end
        chk("rx_stall_no_clr", 32'(cnt), 0);
        tick(1); rx_rd_en = 1'b1; tick(1); rx_rd_en = 1'b0;
        wait_clr(3, seen);
        chk("rx_clr_after_pop", 32'(seen), 1);
        tick(1); core_rd_reg_full = 1'b0;
        tick(1);
        rx_rd_en = 1'b1; tick(3); rx_rd_en = 1'b0;
        @(negedge clk);
        chk("rx_tail_a5", 32'(rx_data), 32'hA5);
        chk("rx_level_one", 32'(rx_level), 1);
        tick(1); rx_rd_en = 1'b1; tick(2); rx_rd_en = 1'b0;
        @(negedge clk);
        chk("err_udf_set", 32'(err_udf), 1);
        tick(1); flush = 1'b1; tick(1); flush = 1'b0;
        @(negedge clk);
        chk("flush_clears_udf", 32'(err_udf), 0);
        chk("flush_rx_data", 32'(rx_data), 0);

        // SDA glitch shorter than the filter, then a real START
        tick(1);
        sda_i = 1'b0; tick(FILT_LEN - 1); sda_i = 1'b1;
        tick(10);
        @(negedge clk);
        chk("glitch_no_busy", 32'(bus_busy), 0);
        tick(1);
        sda_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("start_busy_early", 32'(bus_busy), 0);
        @(negedge clk);
        chk("start_busy_on_time", 32'(bus_busy), 1);

        // SCL frozen while busy
        repeat (STUCK_CYC - 1) @(negedge clk);
        chk("stuck_not_yet", 32'(bus_stuck), 0);
        @(negedge clk);
        chk("stuck_set", 32'(bus_stuck), 1);
        chk("stuck_clears_busy", 32'(bus_busy), 0);
        tick(1);
        sda_i = 1'b1; tick(8);
        sda_i = 1'b0; tick(8);
        @(negedge clk);
        chk("restart_clears_stuck", 32'(bus_stuck), 0);
        chk("restart_busy", 32'(bus_busy), 1);
        tick(1);
        scl_i = 1'b0; tick(6); scl_i = 1'b1; tick(6);
        sda_i = 1'b1; tick(8);
        @(negedge clk);
        chk("stop_clears_busy", 32'(bus_busy), 0);

        // Flush while a byte sits in T_PUSH
        tick(1);
        core_wr_reg_empty = 1'b1;
        tx_data = 8'h33; tx_wr_en = 1'b1; tick(1);
        tx_wr_en = 1'b0; tick(1);
        flush = 1'b1; tick(1); flush = 1'b0;
        wait_wr(5, seen, b);
        chk("flush_suppresses_strobe", 32'(seen), 0);
        chk_reset_vals("flush");

        // Reset while a byte sits in T_PUSH
        tick(1);
        tx_data = 8'h34; tx_wr_en = 1'b1; tick(1);
        tx_wr_en = 1'b0; tick(1);
        rst_sync_n = 1'b0; tick(1); rst_sync_n = 1'b1;
        wait_wr(5, seen, b);
        chk("reset_suppresses_strobe", 32'(seen), 0);
        chk_reset_vals("rst");

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
